sig_monitor: RTL
================

SIG_MONITOR -- requirements
Module: sig_monitor

Interface
REQ-001 SHALL have parameter SIG_BASE, default 32'h0000_1000: byte address of the first signature word.
REQ-002 SHALL have parameter SIG_WORDS, default 8: number of signature words, a power of two, 2..64.
REQ-003 SHALL have parameter TOHOST_ADDR, default 32'h0000_1100: byte address of the test-completion register.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 2000: cycle budget for CAPTURE.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port mem_we, input, 1 bit: core data-memory write strobe (snooped, never stalled).
REQ-008 SHALL have port mem_addr, input, 32 bits: write byte address.
REQ-009 SHALL have port mem_wdata, input, 32 bits: write data.
REQ-010 SHALL have port mem_be, input, 4 bits: byte enables; bit i enables mem_wdata[8i+7:8i].
REQ-011 SHALL have port out_valid, output, 1 bit: a signature word is presented.
REQ-012 SHALL have port out_ready, input, 1 bit: the consumer accepts the presented word.
REQ-013 SHALL have port out_data, output, 32 bits: signature word value.
REQ-014 SHALL have port out_idx, output, $clog2(SIG_WORDS) bits: index of the presented word.
REQ-015 SHALL have port done, output, 1 bit: dump complete, sticky.
REQ-016 SHALL have port pass, output, 1 bit: the test reported pass.
REQ-017 SHALL have port timeout, output, 1 bit: CAPTURE ended by the cycle budget.

Function
REQ-018 SHALL implement FSM states CAPTURE, DUMP and DONE, entering CAPTURE on reset.
REQ-019 SHALL treat a write as a signature hit when, in CAPTURE, mem_we=1, mem_addr[1:0]=0 and SIG_BASE <= mem_addr < SIG_BASE+4*SIG_WORDS.
REQ-020 SHALL on a signature hit update only the bytes of word (mem_addr-SIG_BASE)>>2 enabled by mem_be, with the new value visible on the next cycle.
REQ-021 SHALL ignore misaligned writes, out-of-range writes, and any write made in DUMP or DONE.
REQ-022 SHALL treat a write as a tohost hit when, in CAPTURE, mem_we=1, mem_addr=TOHOST_ADDR, mem_be=4'hF and mem_wdata[0]=1; a tohost write with mem_wdata[0]=0 SHALL be ignored.
REQ-023 SHALL on a tohost hit go to DUMP on the next cycle and register pass=(mem_wdata==32'h1), timeout=0.
REQ-024 SHALL count CAPTURE cycles from 0; when the count reaches TIMEOUT_CYCLES-1 without a tohost hit, SHALL go to DUMP with timeout=1 and pass=0.
REQ-025 SHALL give a tohost hit priority when it occurs in the same cycle as the timeout: timeout=0.
REQ-026 SHALL in DUMP assert out_valid in the first DUMP cycle, with out_idx=0 and out_data equal to buffer word 0.
REQ-027 SHALL keep out_data and out_idx stable while out_valid=1 and out_ready=0.
REQ-028 SHALL on out_valid&&out_ready advance out_idx by 1 on the next cycle; after the handshake of index SIG_WORDS-1 it SHALL enter DONE with out_valid=0.
REQ-029 SHALL sustain one word per cycle when out_ready is held high: SIG_WORDS transfers in SIG_WORDS consecutive cycles.
REQ-030 SHALL output 32'h0 for words never written.
REQ-031 SHALL in DONE hold done=1, out_valid=0, and pass/timeout at their registered values until reset.
REQ-032 SHALL keep out_data and out_idx at 0 whenever out_valid=0.

Reset
REQ-033 SHALL on rst=1 at a rising edge clear out_valid, out_data, out_idx, done, pass, timeout, all buffer words and the cycle counter, and enter CAPTURE, including in the middle of a DUMP.
REQ-034 SHALL ignore snooped writes in any cycle where rst=1.

Verification
REQ-035 Words 0..7 written with 0x11*(i+1), then tohost write 0x1, out_ready=1 -> 8 consecutive beats idx 0..7 with data 0x11..0x88; done=1, pass=1, timeout=0.
REQ-036 Write 0xAABBCCDD to word 2 with be=4'hF, then 0x00000011 with be=4'b0001, then tohost 0x3 -> word 2 dumps as 0xAABBCC11; pass=0, timeout=0.
REQ-037 No tohost write for 2000 cycles -> DUMP starts on cycle 2001, timeout=1, pass=0, unwritten words dump as 0.
REQ-038 During the dump, out_ready toggles 1,0,0,1... -> each word is held stable while out_ready=0; no word is skipped or duplicated; done=1 only after idx 7 is accepted.
REQ-039 Writes to 0x1002 (misaligned), 0x1020 (out of range) and tohost 0x0 -> buffer unchanged, state stays CAPTURE.
REQ-040 rst asserted after idx 3 is accepted -> next cycle all outputs are 0, state is CAPTURE, and the buffer reads as 0 on the next dump.

Source files
------------

// File: rtl/sig_monitor.sv
// rtl/sig_monitor.sv - snoops data-memory writes into a signature buffer and dumps it on test completion
//
// Purpose:
//   While in CAPTURE, writes that land on the signature window are merged
//   byte-wise into a local buffer. A write of an odd value to the tohost
//   register, or the cycle budget running out, ends capture. The buffer
//   is then streamed out one word per handshake, and the block parks in
//   DONE until reset.
//
// Ports:
//   clk        - single clock, all state changes on the rising edge
//   rst        - synchronous active-high reset
//   mem_we     - snooped data-memory write strobe
//   mem_addr   - snooped write byte address
//   mem_wdata  - snooped write data
//   mem_be     - snooped byte enables, bit i covers mem_wdata[8i+7:8i]
//   out_valid  - a signature word is presented
//   out_ready  - consumer accepts the presented word
//   out_data   - presented signature word (0 when out_valid=0)
//   out_idx    - index of the presented word (0 when out_valid=0)
//   done       - dump complete, sticky until reset
//   pass       - test reported pass (tohost value was exactly 1)
//   timeout    - capture was ended by the cycle budget

module sig_monitor #(
  parameter logic [31:0] SIG_BASE       = 32'h0000_1000,
  parameter int          SIG_WORDS      = 8,
  parameter logic [31:0] TOHOST_ADDR    = 32'h0000_1100,
  parameter int          TIMEOUT_CYCLES = 2000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         mem_we,
  input  logic [31:0]                  mem_addr,
  input  logic [31:0]                  mem_wdata,
  input  logic [3:0]                   mem_be,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [31:0]                  out_data,
  output logic [$clog2(SIG_WORDS)-1:0] out_idx,
  output logic                         done,
  output logic                         pass,
  output logic                         timeout
);

  localparam int          IW           = $clog2(SIG_WORDS);
  localparam logic [31:0] SIG_BYTES    = 32'(4 * SIG_WORDS);
  localparam logic [31:0] BUDGET_LAST  = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [IW-1:0] LAST_IDX   = IW'(SIG_WORDS - 1);

  typedef enum logic [1:0] {
    S_CAPTURE,
    S_DUMP,
    S_DONE
  } state_t;

  state_t      state;
  logic [31:0] sig_buf [SIG_WORDS];
  logic [31:0] cyc_cnt;

  logic [31:0]   sig_off;
  logic [IW-1:0] sig_idx;
  logic          sig_hit;
  logic          tohost_hit;
  logic          budget_out;

  // Offset from the window base; a single unsigned compare on the offset
  // together with mem_addr >= SIG_BASE bounds the window on both sides.
  assign sig_off = mem_addr - SIG_BASE;
  assign sig_idx = sig_off[IW+1:2];

  assign sig_hit = (state == S_CAPTURE) && mem_we && (mem_addr[1:0] == 2'b00) &&
                   (mem_addr >= SIG_BASE) && (sig_off < SIG_BYTES);

  assign tohost_hit = (state == S_CAPTURE) && mem_we && (mem_addr == TOHOST_ADDR) &&
                      (mem_be == 4'hF) && mem_wdata[0];

  assign budget_out = (cyc_cnt == BUDGET_LAST);

  // The buffer is frozen outside CAPTURE, so reading it through the
  // registered index gives a word that is stable for the whole beat.
  assign out_data = out_valid ? sig_buf[out_idx] : 32'h0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_CAPTURE;
      cyc_cnt   <= 32'h0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      done      <= 1'b0;
      pass      <= 1'b0;
      timeout   <= 1'b0;
      for (int w = 0; w < SIG_WORDS; w++) begin
        sig_buf[w] <= 32'h0;
      end
    end else begin
      case (state)
        S_CAPTURE: begin
          if (sig_hit) begin
            for (int b = 0; b < 4; b++) begin
              if (mem_be[b]) begin
                sig_buf[sig_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
              end
            end
          end
          // A tohost hit wins over the budget expiring in the same cycle.
          if (tohost_hit) begin
            state     <= S_DUMP;
            pass      <= (mem_wdata == 32'h1);
            timeout   <= 1'b0;
            out_valid <= 1'b1;
            out_idx   <= '0;
          end else if (budget_out) begin
            state     <= S_DUMP;
            pass      <= 1'b0;
            timeout   <= 1'b1;
            out_valid <= 1'b1;
            out_idx   <= '0;
          end else begin
            cyc_cnt <= cyc_cnt + 32'd1;
          end
        end

        S_DUMP: begin
          if (out_ready) begin
            if (out_idx == LAST_IDX) begin
              state     <= S_DONE;
              out_valid <= 1'b0;
              out_idx   <= '0;
              done      <= 1'b1;
            end else begin
              out_idx <= out_idx + 1'b1;
            end
          end
        end

        S_DONE: begin
          // Parked: outputs hold their registered values until reset.
        end

        default: begin
          state <= S_CAPTURE;
        end
      endcase
    end
  end

endmodule
